hpu_seq_ctrl: RTL and testbench

- Run sequencer for the HPU streaming datapath.
- Replaces the hard-wired item-memory count, addr_i/addr_j constants and the software-toggled matw/run bits.
- On one start pulse it fills item memory (matw phase, drives mat_a), then runs the stream phase until exe_ctrl reports s_fin and dst_ctrl emits the final TLAST beat, then raises done/irq.
- Sits between the AXI-Lite register file (config/start) and src_ctrl/s_ctrl/exe_ctrl/dst_ctrl/core (matw, run, mat_a, addr_i, addr_j).

---
 rtl/hpu_pkg.sv | 15 +
 rtl/hpu_seq_ctrl_if.sv | 43 ++++
 rtl/hpu_sat_cnt.sv | 26 ++
 rtl/hpu_seq_ctrl.sv | 117 +++++++++++
 tb/tb_hpu_seq_ctrl.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/hpu_pkg.sv
// Shared definitions for the HPU run sequencer and the register file that decodes its status.
package hpu_pkg;
   localparam int ADDR_W = 20;
   localparam int ITEM_W = 16;
   localparam int CNT_W  = 32;

   // Encoding is visible to software through the status register.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FILL  = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } hpu_state_e;
endpackage

// File: rtl/hpu_seq_ctrl_if.sv
// Control/status bundle between the register file, the downstream stream blocks and the sequencer.
interface hpu_seq_ctrl_if
   import hpu_pkg::*;
#(
   parameter int ADDR_W = hpu_pkg::ADDR_W,
   parameter int ITEM_W = hpu_pkg::ITEM_W,
   parameter int CNT_W  = hpu_pkg::CNT_W
);
   logic              start;
   logic              abort;
   logic              done_clr;
   logic [ITEM_W-1:0] cfg_item_num;
   logic              cfg_skip_fill;
   logic [ADDR_W-1:0] cfg_addr_i;
   logic [ADDR_W-1:0] cfg_addr_j;
   logic              s_fin;
   logic              dst_last_hs;

   logic              matw;
   logic              run;
   logic [ITEM_W-1:0] mat_a;
   logic [ADDR_W-1:0] addr_i;
   logic [ADDR_W-1:0] addr_j;
   logic              busy;
   logic              done;
   logic              irq;
   logic [2:0]        state_o;
   logic [CNT_W-1:0]  cycle_cnt;

   modport master (
      output start, abort, done_clr, cfg_item_num, cfg_skip_fill,
             cfg_addr_i, cfg_addr_j, s_fin, dst_last_hs,
      input  matw, run, mat_a, addr_i, addr_j, busy, done, irq,
             state_o, cycle_cnt
   );

   modport slave (
      input  start, abort, done_clr, cfg_item_num, cfg_skip_fill,
             cfg_addr_i, cfg_addr_j, s_fin, dst_last_hs,
      output matw, run, mat_a, addr_i, addr_j, busy, done, irq,
             state_o, cycle_cnt
   );
endinterface

// File: rtl/hpu_sat_cnt.sv
// Clear/enable counter that sticks at all-ones instead of wrapping.
module hpu_sat_cnt
   import hpu_pkg::*;
#(
   parameter int W = hpu_pkg::CNT_W
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o
);
   logic [W-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i && (cnt_q != {W{1'b1}})) begin
         cnt_q <= cnt_q + W'(1);
      end
   end

   assign cnt_o = cnt_q;
endmodule

// File: rtl/hpu_seq_ctrl.sv
// Run sequencer: fills item memory, runs the stream phase until the last output beat, then flags completion.
module hpu_seq_ctrl
   import hpu_pkg::*;
#(
   parameter int ADDR_W = hpu_pkg::ADDR_W,
   parameter int ITEM_W = hpu_pkg::ITEM_W,
   parameter int CNT_W  = hpu_pkg::CNT_W
) (
   input  logic         AXIS_ACLK,
   input  logic         AXIS_ARESETN,
   hpu_seq_ctrl_if.slave seq_if
);
   hpu_state_e        state_q, state_d;
   logic [ITEM_W-1:0] mat_a_q, mat_a_d;
   logic [ITEM_W-1:0] item_last_q;
   logic [ADDR_W-1:0] addr_i_q, addr_j_q;
   logic              matw_q, run_q, irq_q, done_q;
   logic              start_ok;
   logic              abort_ok;
   logic              cnt_en;

   assign start_ok = seq_if.start & ~seq_if.abort & (state_q == ST_IDLE);
   assign abort_ok = seq_if.abort & (state_q != ST_IDLE);

   always_comb begin
      state_d = state_q;
      mat_a_d = mat_a_q;
      unique case (state_q)
         ST_IDLE: begin
            mat_a_d = '0;
            if (start_ok) begin
               state_d = (seq_if.cfg_skip_fill || (seq_if.cfg_item_num == '0)) ? ST_RUN : ST_FILL;
            end
         end
         ST_FILL: begin
            if (mat_a_q == item_last_q) begin
               state_d = ST_RUN;
               mat_a_d = '0;
            end else begin
               mat_a_d = mat_a_q + ITEM_W'(1);
            end
         end
         ST_RUN: begin
            // Last beat may already be on the bus when exe_ctrl finishes.
            if (seq_if.s_fin) begin
               state_d = seq_if.dst_last_hs ? ST_DONE : ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (seq_if.dst_last_hs) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      if (abort_ok) begin
         state_d = ST_IDLE;
         mat_a_d = '0;
      end
   end

   always_ff @(posedge AXIS_ACLK) begin
      if (!AXIS_ARESETN) begin
         state_q     <= ST_IDLE;
         mat_a_q     <= '0;
         item_last_q <= '0;
         addr_i_q    <= '0;
         addr_j_q    <= '0;
         matw_q      <= 1'b0;
         run_q       <= 1'b0;
         irq_q       <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         mat_a_q <= mat_a_d;
         matw_q  <= (state_d == ST_FILL);
         run_q   <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
         irq_q   <= (state_d == ST_DONE);
         if (start_ok) begin
            addr_i_q    <= seq_if.cfg_addr_i;
            addr_j_q    <= seq_if.cfg_addr_j;
            item_last_q <= seq_if.cfg_item_num - ITEM_W'(1);
         end
         // Setting done wins over a simultaneous clear request.
         if (start_ok) begin
            done_q <= 1'b0;
         end else if ((state_q == ST_DONE) && !seq_if.abort) begin
            done_q <= 1'b1;
         end else if (seq_if.done_clr) begin
            done_q <= 1'b0;
         end
      end
   end

   assign cnt_en = (state_q == ST_FILL) || (state_q == ST_RUN) || (state_q == ST_DRAIN);

   hpu_sat_cnt #(
      .W (CNT_W)
   ) u_cycle_cnt (
      .clk_i  (AXIS_ACLK),
      .rst_ni (AXIS_ARESETN),
      .clr_i  (start_ok),
      .en_i   (cnt_en),
      .cnt_o  (seq_if.cycle_cnt)
   );

   assign seq_if.matw    = matw_q;
   assign seq_if.run     = run_q;
   assign seq_if.mat_a   = mat_a_q;
   assign seq_if.addr_i  = addr_i_q;
   assign seq_if.addr_j  = addr_j_q;
   assign seq_if.busy    = (state_q != ST_IDLE);
   assign seq_if.done    = done_q;
   assign seq_if.irq     = irq_q;
   assign seq_if.state_o = state_q;
endmodule

// File: tb/tb_hpu_seq_ctrl.sv
// Bench for hpu_seq_ctrl: directed and random jobs checked against a per-cycle job timeline.
module tb_hpu_seq_ctrl;
   logic        clk = 1'b0;
   logic        rstn;
   logic        start, abort, done_clr, skip, s_fin, dst;
   logic [15:0] item_num;
   logic [19:0] cfg_ai, cfg_aj;

   int vectors = 0;
   int fails   = 0;
   logic exp_done;

   always #5 clk = ~clk;

   hpu_seq_ctrl_if #(.ADDR_W(20), .ITEM_W(16), .CNT_W(32)) bus_w ();
   hpu_seq_ctrl_if #(.ADDR_W(20), .ITEM_W(16), .CNT_W(8))  bus_n ();

   assign bus_w.start = start;          assign bus_n.start = start;
   assign bus_w.abort = abort;          assign bus_n.abort = abort;
   assign bus_w.done_clr = done_clr;    assign bus_n.done_clr = done_clr;
   assign bus_w.cfg_item_num = item_num; assign bus_n.cfg_item_num = item_num;
   assign bus_w.cfg_skip_fill = skip;   assign bus_n.cfg_skip_fill = skip;
   assign bus_w.cfg_addr_i = cfg_ai;    assign bus_n.cfg_addr_i = cfg_ai;
   assign bus_w.cfg_addr_j = cfg_aj;    assign bus_n.cfg_addr_j = cfg_aj;
   assign bus_w.s_fin = s_fin;          assign bus_n.s_fin = s_fin;
   assign bus_w.dst_last_hs = dst;      assign bus_n.dst_last_hs = dst;

   hpu_seq_ctrl #(.ADDR_W(20), .ITEM_W(16), .CNT_W(32)) u_dut (
      .AXIS_ACLK    (clk),
      .AXIS_ARESETN (rstn),
      .seq_if       (bus_w.slave)
   );

   hpu_seq_ctrl #(.ADDR_W(20), .ITEM_W(16), .CNT_W(8)) u_dut_n (
      .AXIS_ACLK    (clk),
      .AXIS_ARESETN (rstn),
      .seq_if       (bus_n.slave)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input logic [2:0] st, input logic mw, input logic rn,
                                input logic [15:0] ma, input logic irq_e, input logic dn,
                                input logic [19:0] eai, input logic [19:0] eaj,
                                input longint cnt);
      chk("state",   64'(bus_w.state_o), 64'(st));
      chk("matw",    64'(bus_w.matw), 64'(mw));
      chk("run",     64'(bus_w.run), 64'(rn));
      chk("busy",    64'(bus_w.busy), 64'(st != 3'd0));
      chk("mat_a",   64'(bus_w.mat_a), 64'(ma));
      chk("irq",     64'(bus_w.irq), 64'(irq_e));
      chk("done",    64'(bus_w.done), 64'(dn));
      chk("addr_i",  64'(bus_w.addr_i), 64'(eai));
      chk("addr_j",  64'(bus_w.addr_j), 64'(eaj));
      chk("cnt32",   64'(bus_w.cycle_cnt), 64'(cnt));
      chk("cnt8sat", 64'(bus_n.cycle_cnt), (cnt > 255) ? 64'd255 : 64'(cnt));
   endtask

   task automatic idle_inputs();
      start = 0; abort = 0; done_clr = 0; s_fin = 0; dst = 0;
   endtask

   // Cycle 0 carries the start pulse; f and l are the cycles carrying s_fin and the last beat.
   task automatic run_job(input int n, input logic sk, input logic [19:0] ai, input logic [19:0] aj,
                          input int f, input int l, input logic clr_at_done);
      int neff, r0, d;
      logic [2:0] st;
      neff = (sk || n == 0) ? 0 : n;
      r0   = neff + 1;
      d    = (l == f) ? f + 1 : l + 1;
      for (int c = 0; c <= d + 1; c++) begin
         @(negedge clk);
         if (c == 0) begin
            chk("pre_busy", 64'(bus_w.busy), 64'd0);
            chk("pre_done", 64'(bus_w.done), 64'(exp_done));
         end else begin
            if (c <= neff)      st = 3'd1;
            else if (c <= f)    st = 3'd2;
            else if (c < d)     st = 3'd3;
            else if (c == d)    st = 3'd4;
            else                st = 3'd0;
            check_outputs(st, (c <= neff), (c >= r0 && c < d),
                          (c <= neff) ? 16'(c - 1) : 16'd0, (c == d), (c > d),
                          ai, aj, (c - 1 < d - 1) ? longint'(c - 1) : longint'(d - 1));
         end
         idle_inputs();
         if (c == 0) begin
            start = 1; item_num = 16'(n); skip = sk; cfg_ai = ai; cfg_aj = aj;
         end
         if (c == r0 && f > r0) dst = 1;
         if (c == r0 + 1 && r0 + 1 <= f) begin
            start = 1; cfg_ai = ai ^ 20'h5a5a5; cfg_aj = aj ^ 20'h0f0f0; item_num = 16'(n + 3);
         end
         if (c == f) s_fin = 1;
         if (c == l) dst = 1;
         if (clr_at_done && c == d) done_clr = 1;
      end
      exp_done = 1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rstn = 0; idle_inputs();
      item_num = 0; skip = 0; cfg_ai = 0; cfg_aj = 0; exp_done = 0;
      repeat (2) @(negedge clk);
      check_outputs(3'd0, 0, 0, 16'd0, 0, 0, 20'd0, 20'd0, 0);
      rstn = 1;

      run_job(100, 0, 20'd29, 20'd2, 400, 405, 0);
      run_job(100, 1, 20'd7, 20'd3, 10, 12, 0);
      run_job(0, 0, 20'd11, 20'd4, 5, 8, 0);
      run_job(20, 0, 20'd1, 20'd9, 30, 30, 0);

      // Abort in FILL when mat_a reaches 37, then refill from zero.
      for (int c = 0; c <= 44; c++) begin
         @(negedge clk);
         if (c == 38) chk("abort_mat_a", 64'(bus_w.mat_a), 64'd37);
         if (c == 39) check_outputs(3'd0, 0, 0, 16'd0, 0, 0, 20'd33, 20'd5, 38);
         if (c > 39) chk("abort_irq", 64'(bus_w.irq), 64'd0);
         idle_inputs();
         if (c == 0) begin
            start = 1; item_num = 16'd100; skip = 0; cfg_ai = 20'd33; cfg_aj = 20'd5;
         end
         if (c == 38) abort = 1;
      end
      exp_done = 0;
      run_job(50, 0, 20'd77, 20'd6, 60, 64, 0);

      run_job(8, 0, 20'd12, 20'd13, 15, 17, 1);
      @(negedge clk);
      chk("done_held", 64'(bus_w.done), 64'd1);
      done_clr = 1;
      @(negedge clk);
      chk("done_cleared", 64'(bus_w.done), 64'd0);
      done_clr = 0;
      exp_done = 0;

      for (int k = 0; k < 10; k++) begin
         int n, f, l;
         logic sk, clr;
         n   = $urandom_range(0, 40);
         sk  = ($urandom_range(0, 3) == 0);
         f   = ((sk || n == 0) ? 0 : n) + 1 + $urandom_range(0, 20);
         l   = f + $urandom_range(0, 6);
         clr = $urandom_range(0, 1);
         run_job(n, sk, 20'($urandom), 20'($urandom), f, l, clr);
      end

      // Synchronous reset while in RUN.
      for (int c = 0; c <= 9; c++) begin
         @(negedge clk);
         if (c == 8) chk("pre_reset_run", 64'(bus_w.run), 64'd1);
         if (c == 9) check_outputs(3'd0, 0, 0, 16'd0, 0, 0, 20'd0, 20'd0, 0);
         idle_inputs();
         if (c == 0) begin
            start = 1; item_num = 16'd5; skip = 0; cfg_ai = 20'd3; cfg_aj = 20'd4;
         end
         if (c == 8) rstn = 0;
         if (c == 9) rstn = 1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end
endmodule
